// File: rtl/fb_write_dma_if.sv
// Pixel-stream input and Req/Gnt SDRAM write bus of the framebuffer write engine.
// master = the DMA engine, slave = the pixel source / SDRAM controller side.
interface fb_write_dma_if #(
    parameter int PIX_W  = 4,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 18
);
    logic              i_pix_valid;
    logic              o_pix_ready;
    logic [PIX_W-1:0]  i_pix_data;
    logic              o_wr_req;
    logic              i_wr_gnt;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [WORD_W-1:0] o_wr_data;

    modport master (
        input  i_pix_valid, i_pix_data, i_wr_gnt,
        output o_pix_ready, o_wr_req, o_wr_addr, o_wr_data
    );

    modport slave (
        output i_pix_valid, i_pix_data, i_wr_gnt,
        input  o_pix_ready, o_wr_req, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/fb_write_dma.sv
// Packs PIX_W pixels into WORD_W words, queues them and issues Req/Gnt SDRAM writes; FB_WRITE_DMA_STATS_EN adds o_drop_cnt.
// Latency: word push -> o_wr_req next cycle; backpressure: o_pix_ready low only on the final lane while the FIFO is full.
module fb_write_dma #(
    parameter int                PIX_W       = 4,
    parameter int                WORD_W      = 16,
    parameter int                FIFO_AW     = 2,
    parameter int                ADDR_W      = 18,
    parameter int                FRAME_WORDS = 39312,
    parameter logic [ADDR_W-1:0] BUF0_BASE   = 18'h00000,
    parameter logic [ADDR_W-1:0] BUF1_BASE   = 18'h10000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_frame_start,
    fb_write_dma_if.master  bus,
    output logic            o_frame_done,
    output logic            o_overflow,
    output logic            o_disp_buf
`ifdef FB_WRITE_DMA_STATS_EN
    ,
    output logic [15:0]     o_drop_cnt
`endif
);
    localparam int PPW    = WORD_W / PIX_W;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
    localparam int SUM_W  = ((CNT_W > FIFO_AW) ? CNT_W : FIFO_AW) + 2;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PPW - 1);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t              state_q;
    logic [LANE_W-1:0]   lane_q;
    logic [WORD_W-1:0]   pack_q;
    logic [WORD_W-1:0]   fifo_q [DEPTH];
    logic [FIFO_AW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [FIFO_AW:0]    fifo_cnt_q;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                wr_buf_q, frame_cmpl_q;
    logic                req_q, done_q, ovf_q, disp_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   data_q;
    logic [WORD_W-1:0]   pack_d;
    logic [SUM_W-1:0]    queued;
    logic                fifo_full, fifo_empty, frame_full;
    logic                pix_rdy, accept, word_done, push, drop, pop;
    logic                gnt_ok, last_gnt;
    logic [ADDR_W-1:0]   base;

    assign fifo_full  = (fifo_cnt_q == (FIFO_AW+1)'(DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    // Words already committed to this frame: granted, queued, or waiting in the request register.
    assign queued     = SUM_W'(word_cnt_q) + SUM_W'(fifo_cnt_q) + SUM_W'(req_q);
    assign frame_full = (queued >= SUM_W'(FRAME_WORDS));

    assign pix_rdy    = ~rst & ~i_frame_start & ((lane_q != LAST_LANE) | ~fifo_full | frame_full);
    assign accept     = bus.i_pix_valid & pix_rdy;
    assign word_done  = accept & (lane_q == LAST_LANE);
    assign push       = word_done & ~frame_full;
    assign drop       = word_done & frame_full;

    assign gnt_ok     = req_q & bus.i_wr_gnt;
    assign last_gnt   = gnt_ok & (word_cnt_q == CNT_W'(FRAME_WORDS - 1));
    assign pop        = ~i_frame_start & ~fifo_empty & (~req_q | bus.i_wr_gnt);
    assign word_cnt_d = word_cnt_q + CNT_W'(gnt_ok);
    assign base       = wr_buf_q ? BUF1_BASE : BUF0_BASE;

    always_comb begin
        pack_d = pack_q;
        pack_d[lane_q*PIX_W +: PIX_W] = bus.i_pix_data;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= pack_d;
        end
    end

`ifdef FB_WRITE_DMA_STATS_EN
    logic [15:0] drop_q;
    always_ff @(posedge clk) begin
        if (rst || i_frame_start) begin
            drop_q <= '0;
        end else if (drop && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end
    assign o_drop_cnt = drop_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            pack_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            word_cnt_q   <= '0;
            wr_buf_q     <= 1'b0;
            frame_cmpl_q <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            disp_q       <= 1'b1;
        end else begin
            // A grant in the frame_start cycle still belongs to the old frame.
            done_q <= last_gnt;
            if (last_gnt) begin
                disp_q <= wr_buf_q;
            end
            if (i_frame_start) begin
                state_q      <= S_IDLE;
                lane_q       <= '0;
                pack_q       <= '0;
                rd_ptr_q     <= '0;
                wr_ptr_q     <= '0;
                fifo_cnt_q   <= '0;
                word_cnt_q   <= '0;
                req_q        <= 1'b0;
                ovf_q        <= 1'b0;
                frame_cmpl_q <= 1'b0;
                if (frame_cmpl_q || last_gnt) begin
                    wr_buf_q <= ~wr_buf_q;
                end
            end else begin
                if (accept) begin
                    lane_q <= word_done ? '0 : lane_q + 1'b1;
                    pack_q <= word_done ? '0 : pack_d;
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                fifo_cnt_q <= fifo_cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
                if (drop) begin
                    ovf_q <= 1'b1;
                end
                word_cnt_q <= word_cnt_d;
                if (last_gnt) begin
                    frame_cmpl_q <= 1'b1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (pop) begin
                            data_q  <= fifo_q[rd_ptr_q];
                            addr_q  <= base + ADDR_W'(word_cnt_q);
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (bus.i_wr_gnt) begin
                            if (pop) begin
                                data_q <= fifo_q[rd_ptr_q];
                                addr_q <= base + ADDR_W'(word_cnt_d);
                            end else begin
                                req_q   <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_pix_ready = pix_rdy;
    assign bus.o_wr_req    = req_q;
    assign bus.o_wr_addr   = addr_q;
    assign bus.o_wr_data   = data_q;
    assign o_frame_done    = done_q;
    assign o_overflow      = ovf_q;
    assign o_disp_buf      = disp_q;
endmodule

// File: tb/tb_fb_write_dma.sv
// Directed bench for fb_write_dma with an 8-word frame: vector table for the basic pack/issue path,
// hand-written sequences for stall, frame completion, overflow and mid-request frame_start.
module tb_fb_write_dma;
    localparam int FW = 8;

    logic clk = 1'b0;
    logic rst;
    logic frame_start;
    logic frame_done, overflow, disp_buf;
`ifdef FB_WRITE_DMA_STATS_EN
    logic [15:0] drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    fb_write_dma_if #(.PIX_W(4), .WORD_W(16), .ADDR_W(18)) bus ();

    fb_write_dma #(.FRAME_WORDS(FW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_frame_start(frame_start),
        .bus          (bus),
        .o_frame_done (frame_done),
        .o_overflow   (overflow),
        .o_disp_buf   (disp_buf)
`ifdef FB_WRITE_DMA_STATS_EN
        ,
        .o_drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [17:0] gaddr [$];
    logic [15:0] gdata [$];
    int done_cnt = 0;
    int done_at  = -1;

    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            done_at = gaddr.size();
        end
        if (!rst && bus.o_wr_req && bus.i_wr_gnt) begin
            gaddr.push_back(bus.o_wr_addr);
            gdata.push_back(bus.o_wr_data);
        end
    end

    typedef struct {
        logic        fs;
        logic        v;
        logic [3:0]  d;
        logic        g;
        logic        rdy;
        logic        req;
        logic [17:0] addr;
        logic [15:0] data;
        logic        done;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [3:0] pix(input int i);
        return 4'(i * 7 + 3);
    endfunction

    function automatic logic [15:0] wexp(input int s, input int w);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*4 +: 4] = pix(s + 4*w + k);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic fs, input logic v, input logic [3:0] d, input logic g,
                        output logic rdy);
        frame_start     = fs;
        bus.i_pix_valid = v;
        bus.i_pix_data  = d;
        bus.i_wr_gnt    = g;
        @(negedge clk);
        rdy = bus.o_pix_ready;
        @(posedge clk);
        #1;
        frame_start     = 1'b0;
        bus.i_pix_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic g);
        logic r;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, g, r);
    endtask

    task automatic send_words(input int s, input int n, input logic g);
        logic r;
        int budget;
        for (int i = 0; i < 4*n; i++) begin
            budget = 20;
            do begin
                step(1'b0, 1'b1, pix(s + i), g, r);
                budget--;
            end while (!r && budget > 0);
            if (!r) chk("send_timeout", 32'(r), 32'd1);
        end
    endtask

    initial begin
        logic r;
        logic allrdy;

        tbl[0] = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0000, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0000, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0000, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 18'h0, 16'h4321, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 18'h0, 16'h4321, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 18'h0, 16'h4321, 1'b0};

        // Reset: ready must be low while rst is high, even with a valid pixel.
        rst = 1'b1;
        frame_start = 1'b0;
        bus.i_pix_valid = 1'b1;
        bus.i_pix_data = 4'h5;
        bus.i_wr_gnt = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 32'(bus.o_pix_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_req",  32'(bus.o_wr_req),  32'd0);
        chk("rst_addr", 32'(bus.o_wr_addr), 32'd0);
        chk("rst_data", 32'(bus.o_wr_data), 32'd0);
        chk("rst_done", 32'(frame_done),    32'd0);
        chk("rst_ovf",  32'(overflow),      32'd0);
        chk("rst_disp", 32'(disp_buf),      32'd1);
`ifdef FB_WRITE_DMA_STATS_EN
        chk("rst_drop", 32'(drop_cnt), 32'd0);
`endif
        rst = 1'b0;
        bus.i_pix_valid = 1'b0;

        // Pixels 1,2,3,4 with grant high: one-cycle request for 16'h4321 at address 0.
        gaddr.delete(); gdata.delete();
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].fs, tbl[i].v, tbl[i].d, tbl[i].g, r);
            chk($sformatf("t1_rdy[%0d]", i),  32'(r),                32'(tbl[i].rdy));
            chk($sformatf("t1_req[%0d]", i),  32'(bus.o_wr_req),     32'(tbl[i].req));
            chk($sformatf("t1_addr[%0d]", i), 32'(bus.o_wr_addr),    32'(tbl[i].addr));
            chk($sformatf("t1_data[%0d]", i), 32'(bus.o_wr_data),    32'(tbl[i].data));
            chk($sformatf("t1_done[%0d]", i), 32'(frame_done),       32'(tbl[i].done));
        end
        chk("t1_grants", 32'(gaddr.size()), 32'd1);

        // frame_start blocks a presented pixel and restarts the count (incomplete frame).
        step(1'b1, 1'b1, 4'h9, 1'b0, r);
        chk("fs_rdy", 32'(r), 32'd0);

        // Grant held low: 5 words buffered (req reg + 4-deep FIFO), final lane of word 6 stalls.
        gaddr.delete(); gdata.delete();
        allrdy = 1'b1;
        for (int i = 0; i < 23; i++) begin
            step(1'b0, 1'b1, pix(100 + i), 1'b0, r);
            if (!r) allrdy = 1'b0;
        end
        chk("t2_no_stall", 32'(allrdy), 32'd1);
        step(1'b0, 1'b1, pix(123), 1'b0, r);
        chk("t2_stall", 32'(r), 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_req[%0d]", k),  32'(bus.o_wr_req),  32'd1);
            chk($sformatf("t2_addr[%0d]", k), 32'(bus.o_wr_addr), 32'(k));
            chk($sformatf("t2_data[%0d]", k), 32'(bus.o_wr_data), 32'(wexp(100, k)));
            step(1'b0, 1'b0, 4'h0, 1'b1, r);
        end
        chk("t2_idle", 32'(bus.o_wr_req), 32'd0);
        step(1'b0, 1'b1, pix(123), 1'b1, r);
        chk("t2_resume", 32'(r), 32'd1);
        idle(3, 1'b1);
        chk("t2_grants", 32'(gaddr.size()), 32'd6);
        chk("t2_addr5",  32'(gaddr[5]), 32'd5);
        chk("t2_data5",  32'(gdata[5]), 32'(wexp(100, 5)));

        // Incomplete frame: display buffer untouched, rewrite into buffer 0.
        step(1'b1, 1'b0, 4'h0, 1'b0, r);
        chk("t4_disp", 32'(disp_buf), 32'd1);

        // Full 8-word frame: done on the 8th grant, display buffer -> 0.
        gaddr.delete(); gdata.delete();
        done_cnt = 0; done_at = -1;
        send_words(200, 8, 1'b1);
        idle(4, 1'b1);
        chk("t3_grants", 32'(gaddr.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3_addr[%0d]", k), 32'(gaddr[k]), 32'(k));
            chk($sformatf("t3_data[%0d]", k), 32'(gdata[k]), 32'(wexp(200, k)));
        end
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);
        chk("t3_done_at",  32'(done_at),  32'd8);
        chk("t3_disp",     32'(disp_buf), 32'd0);
        chk("t3_ovf",      32'(overflow), 32'd0);

        // Next frame goes to buffer 1.
        step(1'b1, 1'b0, 4'h0, 1'b0, r);
        gaddr.delete(); gdata.delete();
        send_words(300, 1, 1'b1);
        idle(3, 1'b1);
        chk("t3b_grants", 32'(gaddr.size()), 32'd1);
        chk("t3b_addr",   32'(gaddr[0]), 32'h10000);
        chk("t3b_data",   32'(gdata[0]), 32'(wexp(300, 0)));

        // Overflow: 10 words into an 8-word frame (buffer 1 reused, incomplete before).
        step(1'b1, 1'b0, 4'h0, 1'b0, r);
        chk("t5_disp_pre", 32'(disp_buf), 32'd0);
        gaddr.delete(); gdata.delete();
        done_cnt = 0;
        send_words(400, 10, 1'b1);
        idle(4, 1'b1);
        chk("t5_grants",   32'(gaddr.size()), 32'd8);
        chk("t5_addr0",    32'(gaddr[0]), 32'h10000);
        chk("t5_addr7",    32'(gaddr[7]), 32'h10007);
        chk("t5_data7",    32'(gdata[7]), 32'(wexp(400, 7)));
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_ovf",      32'(overflow), 32'd1);
        chk("t5_disp",     32'(disp_buf), 32'd1);
`ifdef FB_WRITE_DMA_STATS_EN
        chk("t5_drop", 32'(drop_cnt), 32'd2);
`endif
        step(1'b1, 1'b0, 4'h0, 1'b0, r);
        chk("t5_ovf_clr", 32'(overflow), 32'd0);
`ifdef FB_WRITE_DMA_STATS_EN
        chk("t5_drop_clr", 32'(drop_cnt), 32'd0);
`endif

        // frame_start while requesting with grant low and lane 2 partially packed.
        gaddr.delete(); gdata.delete();
        send_words(500, 1, 1'b0);
        idle(1, 1'b0);
        chk("t6_req",  32'(bus.o_wr_req),  32'd1);
        chk("t6_addr", 32'(bus.o_wr_addr), 32'h00000);
        chk("t6_data", 32'(bus.o_wr_data), 32'(wexp(500, 0)));
        step(1'b0, 1'b1, pix(504), 1'b0, r);
        step(1'b0, 1'b1, pix(505), 1'b0, r);
        step(1'b1, 1'b1, pix(506), 1'b0, r);
        chk("t6_fs_rdy", 32'(r), 32'd0);
        chk("t6_req_drop", 32'(bus.o_wr_req), 32'd0);
        send_words(600, 1, 1'b1);
        idle(3, 1'b1);
        chk("t6_grants", 32'(gaddr.size()), 32'd1);
        chk("t6_gaddr",  32'(gaddr[0]), 32'h00000);
        chk("t6_gdata",  32'(gdata[0]), 32'(wexp(600, 0)));
        chk("t6_disp",   32'(disp_buf), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
